// File: rtl/norm_pkg.sv
// Shared encodings for the shift normalizer: FSM state codes and direction constants.
package norm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_normalizer.sv
// Iterative one-bit-per-cycle normalizer with valid/ready handshakes on both sides.
// Define NORM_DIR_EN to add the dire port and toward-LSB normalization.
//
// state    | meaning
// ST_IDLE  | waiting for an operand, in_ready=1
// ST_SHIFT | shifting the working copy until its end bit is 1 (or it is zero)
// ST_DONE  | result presented, held until out_ready
module shift_normalizer
  import norm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef NORM_DIR_EN
  input  logic             dire,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    count;
  logic             dir;
  logic             hit;

`ifdef NORM_DIR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= DIR_LEFT;
    end else if (state == ST_IDLE && in_valid) begin
      dir <= dire;
    end
  end
`else
  assign dir = DIR_LEFT;
`endif

  // The bit that ends the search sits at the end we are normalizing toward.
  assign hit = (dir == DIR_RIGHT) ? work[0] : work[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      work      <= '0;
      count     <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            count <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (work == '0) begin
            out_data  <= '0;
            out_count <= '0;
            out_zero  <= 1'b1;
            state     <= ST_DONE;
          end else if (hit) begin
            out_data  <= work;
            out_count <= count;
            out_zero  <= 1'b0;
            state     <= ST_DONE;
          end else begin
            work  <= (dir == DIR_RIGHT) ? {1'b0, work[WIDTH-1:1]}
                                        : {work[WIDTH-2:0], 1'b0};
            count <= count + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer (WIDTH=8); covers toward-LSB mode when NORM_DIR_EN is defined.
module tb_shift_normalizer;
  import norm_pkg::*;

  localparam int W  = 8;
  localparam int CW = 3;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] count;
    logic          zero;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          dire;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_zero;
  logic          out_valid;
  logic          out_ready;
  logic          rdy_ctrl;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  shift_normalizer #(.WIDTH(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef NORM_DIR_EN
    .dire      (dire),
`endif
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: position of the highest (left) or lowest (right) set bit decides everything.
  function automatic exp_t model(input logic [W-1:0] x, input logic right);
    exp_t e;
    int   p;
    if (x == '0) begin
      e.data = '0; e.count = '0; e.zero = 1'b1; e.lat = 1;
      return e;
    end
    p = 0;
    if (!right) begin
      for (int i = 0; i < W; i++) if (x[i]) p = i;
      e.count = CW'(W - 1 - p);
      e.data  = x << (W - 1 - p);
    end else begin
      for (int i = W - 1; i >= 0; i--) if (x[i]) p = i;
      e.count = CW'(p);
      e.data  = x >> p;
    end
    e.zero = 1'b0;
    e.lat  = int'(e.count) + 1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: pops on each new result, checks latency and holds while presented.
  initial begin : monitor
    exp_t cur;
    bit   have_cur;
    int   acc_cyc;
    logic prev_v;
    have_cur = 0;
    acc_cyc  = 0;
    prev_v   = 1'b0;
    cur      = '{default: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v   = 1'b0;
        have_cur = 0;
        continue;
      end
      check("ready_valid_overlap", {31'd0, in_ready & out_valid}, 32'd0);
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output", "out_valid rose with no pending operand");
          have_cur = 0;
        end else begin
          cur      = sb.pop_front();
          have_cur = 1;
          check("out_data",  {24'd0, out_data},  {24'd0, cur.data});
          check("out_count", {29'd0, out_count}, {29'd0, cur.count});
          check("out_zero",  {31'd0, out_zero},  {31'd0, cur.zero});
          check("latency",   cyc - acc_cyc,      cur.lat);
        end
      end else if (out_valid && have_cur) begin
        check("hold_data",  {24'd0, out_data},  {24'd0, cur.data});
        check("hold_count", {29'd0, out_count}, {29'd0, cur.count});
        check("hold_zero",  {31'd0, out_zero},  {31'd0, cur.zero});
      end
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      prev_v = out_valid;
    end
  end

  initial begin : ready_gen
    forever begin
      @(negedge clk);
      #1;
      if (!rdy_ctrl) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+#1; returns once in_ready is seen or the budget runs out.
  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic dr);
    bit   ok;
    logic eff;
    wait_ready(ok);
    if (!ok) begin
      fail_now("ready_timeout", "in_ready never asserted");
      return;
    end
`ifdef NORM_DIR_EN
    eff = dr;
`else
    eff = DIR_LEFT;
`endif
    in_valid = 1'b1;
    in_data  = d;
    dire     = dr;
    sb.push_back(model(d, eff));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    dire     = 1'($urandom);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, "_out_data"},  {24'd0, out_data},  32'd0);
    check({tag, "_out_count"}, {29'd0, out_count}, 32'd0);
    check({tag, "_out_zero"},  {31'd0, out_zero},  32'd0);
  endtask

  initial begin : stim
    bit           ok;
    int           sel;
    logic [W-1:0] d;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    dire      = DIR_LEFT;
    out_ready = 1'b0;
    rdy_ctrl  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1;

    send(8'b0001_0110, DIR_LEFT);
    send(8'b1000_0000, DIR_LEFT);
    send(8'h00, DIR_LEFT);
    send(8'h01, DIR_LEFT);
    send(8'hFF, DIR_LEFT);
`ifdef NORM_DIR_EN
    send(8'b0110_1000, DIR_RIGHT);
    send(8'h80, DIR_RIGHT);
    send(8'h01, DIR_RIGHT);
    send(8'h00, DIR_RIGHT);
`endif

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      d = '0;
      else if (sel == 1) d = W'(1) << $urandom_range(0, W - 1);
      else               d = W'($urandom);
      send(d, 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // Backpressure: hold a result while in_valid offers another operand.
    wait_ready(ok);
    rdy_ctrl  = 1'b1;
    out_ready = 1'b0;
    send(8'h80, DIR_LEFT);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    if (!out_valid) fail_now("valid_timeout", "out_valid never asserted");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data",  {24'd0, out_data},  32'h80);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_keep_out_data",     {24'd0, out_data},  32'h80);
    repeat (3) @(negedge clk);
    check("bp_no_capture", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rdy_ctrl = 1'b0;

    // Reset in the third SHIFT cycle of an operand with seven leading zeros.
    wait_ready(ok);
    if (!ok) fail_now("ready_timeout", "in_ready never asserted before abort test");
    in_valid = 1'b1;
    in_data  = 8'h01;
    dire     = DIR_LEFT;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("abort");
    @(posedge clk);
    #1;

    send(8'b0001_0110, DIR_LEFT);
    send(8'h00, DIR_LEFT);

    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) fail_now("drain_timeout", "results still pending at end");
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
